score_counter: RTL and testbench



---
 rtl/score_counter_if.sv | 30 +++
 rtl/score_counter.sv | 130 +++++++++++++
 tb/tb_score_counter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/score_counter_if.sv
// Game-side bundle for score_counter: run control, tick/bonus strobes,
// score and status outputs.
interface score_counter_if #(
    parameter int SCORE_W = 32,
    parameter int BONUS_W = 8
);
    logic               start;
    logic               tick_en;
    logic               hit;
    logic               bonus_valid;
    logic [BONUS_W-1:0] bonus_pts;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               running;
    logic               game_over;
    logic               point_pulse;
    logic               new_record;

    modport master (
        output start, tick_en, hit, bonus_valid, bonus_pts,
        input  score, high_score, running, game_over,
        input  point_pulse, new_record
    );

    modport slave (
        input  start, tick_en, hit, bonus_valid, bonus_pts,
        output score, high_score, running, game_over,
        output point_pulse, new_record
    );
endinterface

// File: rtl/score_counter.sv
// Survival/bonus score counter with saturating score and run FSM.
// Define SCORE_HISCORE_EN to build the session high-score register.
module score_counter #(
    parameter int               SCORE_W         = 32,
    parameter int               TICKS_PER_POINT = 10,
    parameter int               BONUS_W         = 8,
    parameter logic [SCORE_W-1:0] INIT_SCORE    = '0
) (
    input logic clk,
    input logic reset,
    score_counter_if.slave bus
);
    localparam int DIV_W =
        (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKS_PER_POINT - 1);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_nxt;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_nxt;
    logic [SCORE_W:0]   sum;
    logic               earn;
    logic               pulse_nxt;
    logic               running_q;
    logic               over_q;
    logic               pulse_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            running_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            running_q <= (state_nxt == RUN);
            over_q    <= (state_nxt == OVER);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (bus.hit)   state_nxt = OVER;
            OVER:    if (bus.start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // hit wins over tick and bonus; the score is frozen on that edge
    always_comb begin
        div_nxt   = div_q;
        score_nxt = score_q;
        pulse_nxt = 1'b0;
        earn      = 1'b0;
        sum       = '0;
        unique case (state)
            IDLE, OVER: begin
                if (bus.start) begin
                    score_nxt = INIT_SCORE;
                    div_nxt   = '0;
                end
            end
            RUN: begin
                if (!bus.hit) begin
                    if (bus.tick_en) begin
                        if (div_q == DIV_LAST) begin
                            div_nxt = '0;
                            earn    = 1'b1;
                        end else begin
                            div_nxt = div_q + DIV_W'(1);
                        end
                    end
                    sum = {1'b0, score_q}
                        + (SCORE_W+1)'(earn)
                        + (bus.bonus_valid ? (SCORE_W+1)'(bus.bonus_pts)
                                           : '0);
                    score_nxt = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
                    pulse_nxt = (score_nxt > score_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            score_q <= INIT_SCORE;
            pulse_q <= 1'b0;
        end else begin
            div_q   <= div_nxt;
            score_q <= score_nxt;
            pulse_q <= pulse_nxt;
        end
    end

`ifdef SCORE_HISCORE_EN
    logic [SCORE_W-1:0] hs_q;
    logic               rec_q;
    logic               beat;

    assign beat = (state == RUN) && bus.hit && (score_q > hs_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q  <= '0;
            rec_q <= 1'b0;
        end else begin
            rec_q <= beat;
            if (beat) hs_q <= score_q;
        end
    end

    assign bus.high_score = hs_q;
    assign bus.new_record = rec_q;
`else
    assign bus.high_score = '0;
    assign bus.new_record = 1'b0;
`endif

    assign bus.score       = score_q;
    assign bus.running     = running_q;
    assign bus.game_over   = over_q;
    assign bus.point_pulse = pulse_q;
endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: directed scenarios then random traffic,
// all checked against a tick-counting reference model.
module tb_score_counter;
    localparam int SW   = 8;
    localparam int TPP  = 10;
    localparam int BW   = 8;
    localparam int INIT = 5;
    localparam int SMAX = (1 << SW) - 1;
`ifdef SCORE_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // reference model: 0 idle, 1 run, 2 over
    int m_st, m_score, m_ticks, m_hs;
    bit m_pulse, m_rec;

    score_counter_if #(.SCORE_W(SW), .BONUS_W(BW)) bus ();

    score_counter #(
        .SCORE_W(SW),
        .TICKS_PER_POINT(TPP),
        .BONUS_W(BW),
        .INIT_SCORE(SW'(INIT))
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".score"}, 32'(bus.score), 32'(m_score));
        chk({tag, ".high"}, 32'(bus.high_score), 32'(m_hs));
        chk({tag, ".running"}, 32'(bus.running), 32'(m_st == 1));
        chk({tag, ".over"}, 32'(bus.game_over), 32'(m_st == 2));
        chk({tag, ".pulse"}, 32'(bus.point_pulse), 32'(m_pulse));
        chk({tag, ".record"}, 32'(bus.new_record), 32'(m_rec));
    endtask

    task automatic model_reset();
        m_st = 0; m_score = INIT; m_ticks = 0; m_hs = 0;
        m_pulse = 0; m_rec = 0;
    endtask

    task automatic model_step(input bit s, t, h, bv, input int bp);
        int add, ns;
        m_pulse = 0;
        m_rec   = 0;
        if (m_st != 1) begin
            if (s) begin
                m_st = 1; m_score = INIT; m_ticks = 0;
            end
        end else if (h) begin
            m_st = 2;
            if (HS_EN && m_score > m_hs) begin
                m_hs  = m_score;
                m_rec = 1;
            end
        end else begin
            add = bv ? bp : 0;
            if (t) begin
                m_ticks++;
                if (m_ticks % TPP == 0) add++;
            end
            ns = (m_score + add > SMAX) ? SMAX : m_score + add;
            m_pulse = (ns > m_score);
            m_score = ns;
        end
    endtask

    task automatic drive(input string tag, input bit s, t, h, bv,
                         input int bp);
        bus.start       = s;
        bus.tick_en     = t;
        bus.hit         = h;
        bus.bonus_valid = bv;
        bus.bonus_pts   = BW'(bp);
        model_step(s, t, h, bv, bp);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int pc;
        bus.start = 0; bus.tick_en = 0; bus.hit = 0;
        bus.bonus_valid = 0; bus.bonus_pts = '0;
        model_reset();

        #1 reset = 1'b0;
        #1 check_all("reset");
        @(posedge clk);
        #1 reset = 1'b1;

        drive("idle_ign", 0, 1, 1, 1, 50);
        drive("idle_ign", 0, 1, 0, 1, 50);

        drive("start", 1, 0, 0, 0, 0);
        pc = 0;
        for (int i = 0; i < 25; i++) begin
            drive("survive", 0, 1, 0, 0, 0);
            pc += int'(bus.point_pulse);
        end
        chk("survive.pulses", 32'(pc), 32'd2);

        #1 reset = 1'b0;
        #1 model_reset();
        check_all("rst_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check_all("rst_hold");
        end
        reset = 1'b1;

        drive("hs1", 1, 0, 0, 0, 0);
        drive("hs1", 0, 0, 0, 1, 7);
        drive("hs1_end", 0, 0, 1, 0, 0);
        drive("hs1_after", 0, 1, 0, 0, 0);
        drive("hs2", 1, 0, 0, 0, 0);
        drive("hs2", 0, 0, 0, 1, 7);
        drive("hs2_end", 0, 0, 1, 0, 0);
        drive("hs3", 1, 0, 0, 0, 0);
        drive("hs3_end", 0, 0, 1, 0, 0);

        drive("prio", 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) drive("prio_tk", 0, 1, 0, 0, 0);
        drive("prio_hit", 0, 1, 1, 1, 50);
        for (int i = 0; i < 3; i++) drive("frozen", 0, 1, 0, 1, 9);

        drive("restart", 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive("restart_tk", 0, 1, 0, 0, 0);

        drive("sat_b244", 0, 0, 0, 1, 244);
        for (int i = 0; i < 9; i++) drive("sat_tk", 0, 1, 0, 0, 0);
        drive("sat_pt_b3", 0, 1, 0, 1, 3);
        drive("sat_b10", 0, 0, 0, 1, 10);
        drive("sat_hold", 0, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) drive("sat_tk2", 0, 1, 0, 0, 0);
        drive("sat_b0", 0, 0, 0, 1, 0);
        drive("sat_end", 0, 0, 1, 0, 0);

        for (int i = 0; i < 600; i++) begin
            drive("rand",
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0,
                  $urandom_range(0, 4) == 0,
                  ($urandom_range(0, 3) == 0) ? 0
                      : int'($urandom_range(0, 60)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
